// File: rtl/mux_select_bank_pkg.sv
// Shared word and array types for the word-select bank.
// Also holds the fixed geometry constants for the mux trees.
package mux_select_bank_pkg;

   localparam int WORD_W_DEFAULT = 32;
   localparam int NUM_WORDS      = 32;
   localparam int TREE_LEAVES    = 16;
   localparam int TREE_NODES     = 2 * TREE_LEAVES - 1;

   typedef logic [WORD_W_DEFAULT-1:0] word_t;
   typedef word_t word_array_t [NUM_WORDS];

endpackage

// File: rtl/mux_select_bank_mux2_cell.sv
// N-bit 2:1 multiplexer primitive: b when sel is high, a otherwise.
module mux2_cell #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sel,
   output logic [N-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux_select_bank.sv
// 2:1, 16:1 and 32:1 word selects over a shared 32-word array,
// with combinational outputs plus asynchronously reset registered copies.
module mux_select_bank
   import mux_select_bank_pkg::*;
#(
   parameter int N = WORD_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d [NUM_WORDS],
   input  logic         sel1,
   input  logic [3:0]   sel4,
   input  logic [4:0]   sel5,
   output logic [N-1:0] y2,
   output logic [N-1:0] y16,
   output logic [N-1:0] y32,
   output logic [N-1:0] y2_q,
   output logic [N-1:0] y16_q,
   output logic [N-1:0] y32_q
);

   // Three independent 16-leaf trees in heap order: node 1 is the root,
   // nodes 16..31 are leaves. Tree 0 feeds y16; trees 1 and 2 feed y32.
   logic [N-1:0] node     [3][1:TREE_NODES];
   logic [3:0]   tree_sel [3];

   assign tree_sel[0] = sel4;
   assign tree_sel[1] = sel5[3:0];
   assign tree_sel[2] = sel5[3:0];

   generate
      for (genvar ti = 0; ti < 3; ti++) begin : g_tree
         localparam int BASE = (ti == 2) ? TREE_LEAVES : 0;

         for (genvar li = 0; li < TREE_LEAVES; li++) begin : g_leaf
            assign node[ti][TREE_LEAVES + li] = d[BASE + li];
         end

         // Depth of node gi is floor(log2(gi)); the deepest level uses sel bit 0.
         for (genvar gi = 1; gi < TREE_LEAVES; gi++) begin : g_node
            localparam int DEPTH = $clog2(gi + 1) - 1;
            localparam int SBIT  = 3 - DEPTH;

            mux2_cell #(.N(N)) u_cell (
               .a   (node[ti][2*gi]),
               .b   (node[ti][2*gi + 1]),
               .sel (tree_sel[ti][SBIT]),
               .y   (node[ti][gi])
            );
         end
      end
   endgenerate

   assign y16 = node[0][1];

   mux2_cell #(.N(N)) u_join32 (
      .a   (node[1][1]),
      .b   (node[2][1]),
      .sel (sel5[4]),
      .y   (y32)
   );

   mux2_cell #(.N(N)) u_mux2 (
      .a   (d[0]),
      .b   (d[1]),
      .sel (sel1),
      .y   (y2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y2_q  <= '0;
         y16_q <= '0;
         y32_q <= '0;
      end else begin
         y2_q  <= y2;
         y16_q <= y16;
         y32_q <= y32;
      end
   end

endmodule

// File: tb/tb_mux_select_bank.sv
// Directed and random checks of the word-select bank, combinational and registered paths.
module tb_mux_select_bank;
   import mux_select_bank_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   word_t        d [NUM_WORDS];
   logic         sel1;
   logic [3:0]   sel4;
   logic [4:0]   sel5;
   word_t        y2, y16, y32, y2_q, y16_q, y32_q;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux_select_bank #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .sel1  (sel1),
      .sel4  (sel4),
      .sel5  (sel5),
      .y2    (y2),
      .y16   (y16),
      .y32   (y32),
      .y2_q  (y2_q),
      .y16_q (y16_q),
      .y32_q (y32_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
      end else begin
         $display("ok   %s got=%08h", tag, obs);
      end
   endtask

   task automatic chk_quiet(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
      end
   endtask

   word_t old15, old1;
   word_t rnd [NUM_WORDS];

   initial begin
      rst_n = 1'b0;
      sel1  = 1'b0;
      sel4  = 4'd0;
      sel5  = 5'd0;
      for (int i = 0; i < NUM_WORDS; i++) d[i] = 32'h1000_0000 + 32'(i);
      #1;
      chk("rst_y2_q",  y2_q,  32'h0);
      chk("rst_y16_q", y16_q, 32'h0);
      chk("rst_y32_q", y32_q, 32'h0);

      // Exhaustive select sweep over fixed data.
      for (int s = 0; s < 2; s++) begin
         sel1 = 1'(s);
         #10;
         chk($sformatf("exh_y2_s%0d", s), y2, 32'h1000_0000 + 32'(s));
      end
      for (int s = 0; s < 16; s++) begin
         sel4 = 4'(s);
         #10;
         chk($sformatf("exh_y16_s%0d", s), y16, 32'h1000_0000 + 32'(s));
      end
      for (int s = 0; s < 32; s++) begin
         sel5 = 5'(s);
         #10;
         chk($sformatf("exh_y32_s%0d", s), y32, 32'h1000_0000 + 32'(s));
      end
      chk("exh_y32_31_const", y32, 32'h1000_001F);
      chk("rst_hold_y32_q", y32_q, 32'h0);

      // Random regression: bench keeps its own copy of the data.
      for (int it = 0; it < 1000; it++) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            rnd[i] = $urandom;
            d[i]   = rnd[i];
         end
         for (int s = 0; s < 32; s++) begin
            sel1 = 1'(s & 1);
            sel4 = 4'(s & 15);
            sel5 = 5'(s);
            #1;
            chk_quiet("rnd_y2",  y2,  rnd[s & 1]);
            chk_quiet("rnd_y16", y16, rnd[s & 15]);
            chk_quiet("rnd_y32", y32, rnd[s]);
            if (bad != 0) begin
               $display("FAIL rnd_abort iter=%0d sel=%0d", it, s);
               $fatal(1, "random regression mismatch");
            end
         end
      end
      $display("ok   rnd_regression 1000 iterations");

      // Isolation: only d[15] may move y16, only d[1] may move y2.
      for (int i = 0; i < NUM_WORDS; i++) d[i] = 32'h1000_0000 + 32'(i);
      sel4 = 4'hF;
      sel1 = 1'b1;
      sel5 = 5'd31;
      #10;
      old15 = 32'h1000_000F;
      old1  = 32'h1000_0001;
      for (int i = 31; i >= 2; i--) begin
         d[i] = ~d[i];
         #10;
         chk_quiet($sformatf("iso_y16_d%0d", i), y16, (i <= 15) ? ~old15 : old15);
         chk_quiet($sformatf("iso_y2_d%0d", i), y2, old1);
      end
      $display("ok   iso_sweep");
      d[31] = 32'hDEAD_BEEF;
      #10;
      chk("iso_y32_deadbeef", y32, 32'hDEAD_BEEF);

      // Bit extremes.
      d[0]  = 32'h0000_0000;
      d[1]  = 32'hFFFF_FFFF;
      d[31] = 32'hAAAA_5555;
      sel1 = 1'b0; sel4 = 4'd1; sel5 = 5'd31;
      #10;
      chk("ext_y2_zero",  y2,  32'h0000_0000);
      chk("ext_y16_ones", y16, 32'hFFFF_FFFF);
      chk("ext_y32_alt",  y32, 32'hAAAA_5555);
      sel1 = 1'b1; sel4 = 4'd0; sel5 = 5'd1;
      #10;
      chk("ext_y2_ones",  y2,  32'hFFFF_FFFF);
      chk("ext_y16_zero", y16, 32'h0000_0000);
      chk("ext_y32_ones", y32, 32'hFFFF_FFFF);
      sel5 = 5'd0;
      #10;
      chk("ext_y32_zero", y32, 32'h0000_0000);

      // Registered path.
      @(negedge clk);
      rst_n = 1'b1;
      sel5  = 5'd5;
      d[5]  = 32'h0000_0005;
      d[9]  = 32'h1000_0009;
      sel1  = 1'b1;
      sel4  = 4'd0;
      @(negedge clk);
      chk("reg_y32_q_first", y32_q, 32'h0000_0005);
      chk("reg_y2_q_first",  y2_q,  32'hFFFF_FFFF);
      chk("reg_y16_q_first", y16_q, 32'h0000_0000);
      sel5 = 5'd9;
      #1;
      chk("reg_y32_q_before_edge", y32_q, 32'h0000_0005);
      @(negedge clk);
      chk("reg_y32_q_next_edge", y32_q, 32'h1000_0009);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_y32_q", y32_q, 32'h0);
      chk("mid_rst_y2_q",  y2_q,  32'h0);
      chk("mid_rst_y16_q", y16_q, 32'h0);
      chk("mid_rst_y32_live", y32, 32'h1000_0009);
      sel5 = 5'd31;
      #1;
      chk("mid_rst_y32_track", y32, 32'hAAAA_5555);
      @(posedge clk);
      #1;
      chk("rst_hold_edge_y32_q", y32_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_y32_q", y32_q, 32'hAAAA_5555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_select_bank.md
Name: mux_select_bank

Overview:
- Combinational word-select bank: one 2:1, one 16:1 and one 32:1 multiplexer over a shared array of 32 data words.
- Each multiplexer has its own select input and a zero-latency output.
- A registered copy of each output is also provided for timing-closed consumers.
- Used as the register-file read-port and writeback-select building block in the datapath.

Parameters:
- N, 32, width in bits of every data word and every output.

Ports:
- clk  input  1  rising-edge clock; drives the registered copies only.
- rst_n  input  1  asynchronous active-low reset; clears the registered copies only.
- d  input  32 x N  data word array d[0]..d[31].
- sel1  input  1  select for the 2:1 path.
- sel4  input  4  select for the 16:1 path.
- sel5  input  5  select for the 32:1 path.
- y2  output  N  combinational: d[sel1].
- y16  output  N  combinational: d[sel4].
- y32  output  N  combinational: d[sel5].
- y2_q  output  N  registered y2.
- y16_q  output  N  registered y16.
- y32_q  output  N  registered y32.

Behaviour:
- y2 = d[0] when sel1=0, d[1] when sel1=1.
  - y2 ignores d[2..31].
- y16 = d[sel4], selecting among d[0..15] only.
  - y16 ignores d[16..31].
- y32 = d[sel5], selecting among all 32 words.
- Combinational paths:
  - Zero latency, no clock or reset dependence.
  - Output reflects any change on d or a select within the same delta/settle time.
  - All codes of each select are valid: no out-of-range case, no default word.
- Bit exactness: every output bit equals the selected input bit; no inversion, extension or truncation at any N.
- Registered copies:
  - On each rising clk, y*_q samples the current combinational y*.
  - One-cycle latency.
  - On rst_n low, y2_q, y16_q and y32_q go to 0 immediately (asynchronous) and hold 0 while rst_n is low.
  - The first rising edge with rst_n high loads the live value.
  - Combinational outputs are unaffected by reset.
- Reset mid-operation: registered outputs clear at once; combinational outputs keep tracking the inputs.
- Simultaneous select and data change: the output settles to the new d[new sel]. No glitch-free requirement on combinational outputs; the registered outputs are the glitch-free ones.
- X/Z on a select: no defined value required; simulation X-propagation is acceptable.
- Sim settle budget for the bench: outputs stable within 10 ns of an input change.

Decomposition:
- Shared package: constant for the default word width (32) and a word typedef of N bits.
- The array type for the 32-word input belongs in the same package.
- One natural sub-module: mux2_cell, an N-bit 2:1 primitive.
- The 16:1 path is a 4-level tree of mux2_cell.
  - Level k uses select bit k; the LSB selects at the leaves.
- The 32:1 path is two 16:1 trees over d[0..15] and d[16..31], joined by a final mux2_cell on sel5[4].
  - The d[0..15] tree may be shared with the 16:1 path only if sel4 and sel5[3:0] are separately muxed. Build it as a separate tree.
- The 2:1 path is a single mux2_cell.
- Registered copies: one always_ff block with async reset.

Test Plan:
- Exhaustive select, fixed data: d[i]=32'h1000_0000+i. Sweep sel1 over 0..1, sel4 over 0..15, sel5 over 0..31, waiting 10 ns each.
  - Required: y2=d[sel1], y16=d[sel4], y32=d[sel5], e.g. sel5=31 gives 32'h1000_001F.
- Random regression: 1000 iterations; all 32 words from urandom, full select sweep per iteration.
  - Required: every output equals d[select] exactly; stop with fatal on the first mismatch.
- Isolation: sel4=4'hF, sel1=1; change d[16..31] and d[2..15] only.
  - Required: y16 changes only on d[15] and y2 only on d[1]. Set d[31]=32'hDEAD_BEEF with sel5=31: y32=32'hDEAD_BEEF.
- Bit extremes: d[0]=0, d[1]=32'hFFFF_FFFF, d[31]=32'hAAAA_5555; toggle selects.
  - Required: outputs match bit-exact, including all-ones and alternating patterns.
- Registered path: rst_n=0 gives all y*_q=0 with no clock edge.
  - Release reset, set sel5=5, d[5]=32'h0000_0005. After 1 rising edge: y32_q=5.
  - Change sel5: y32_q updates on the following edge.
  - Assert rst_n low mid-cycle: y32_q=0 immediately while y32 keeps tracking.
